pcd8544_spi_receiver: RTL and testbench
=======================================

Name: pcd8544_spi_receiver

Overview:
- SPI responder for the PCD8544 (Nokia 5110) protocol produced by spi_master; models the display end of the link.
- Samples sce/sclk/mosi/dc/rst, assembles bytes MSB-first, decodes basic and extended commands, tracks the X/Y address pointer, and emits framebuffer write strobes.
- Sits in the bench or on-FPGA loopback so drawing sequences can be checked without the physical LCD.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on lcd_* inputs (min 2).
- X_COLS, 84, columns; X range 0..X_COLS-1.
- Y_BANKS, 6, 8-pixel banks; Y range 0..Y_BANKS-1.

Ports:
- clock  in  1  system clock; lcd_sclk must run at ≤ clock/8.
- reset  in  1  one clock; reset is asynchronous and active-high.
- lcd_sce  in  1  chip enable, active-low.
- lcd_sclk  in  1  serial clock; data sampled on rising edge.
- lcd_mosi  in  1  serial data, MSB first.
- lcd_dc  in  1  0 = command, 1 = data; sampled with bit 0.
- lcd_rst  in  1  display reset, active-low.
- wr_en  out  1  one-cycle framebuffer write strobe.
- wr_addr  out  9  Y*X_COLS+X of the written byte.
- wr_data  out  8  data byte.
- cmd_valid  out  1  one-cycle strobe per decoded command byte.
- cmd_byte  out  8  last command byte.
- pd, v_mode, h_ext  out  1 each  function-set bits 2/1/0.
- disp_mode  out  2  {D,E} from display-control.
- vop  out  7  Vop setting. bias  out  3. tc  out  2.
- x_ptr  out  7, y_ptr  out  3  current address pointer.
- rd_addr  in  9, rd_data  out  8  framebuffer read port.

Behaviour:
- Reset (reset=1, or synchronised lcd_rst=0): all outputs 0, bit counter 0, pd=1, x_ptr=0, y_ptr=0.
- Inputs pass through SYNC_STAGES flops; sclk rising edge is detected on synchronised samples. Edges seen while synchronised sce=1 are ignored.
- Synchronised sce rising mid-byte discards the partial byte and clears the bit counter; no strobe.
- Shift register is updated on each rising edge. On the 8th bit, dc is latched and the byte completes. Strobes assert exactly 1 cycle after the 8th-edge detect. Total latency from the pin edge is SYNC_STAGES+2 clocks.
- Receiver states: IDLE (sce high) -> SHIFT (sce low, counting 0..7) -> DISPATCH (1 cycle) -> SHIFT. Any state goes to IDLE when sce=1.
- Data byte (dc=1):
  - wr_en=1, wr_addr = y*X_COLS+x, wr_data = byte.
  - Pointer then advances:
    - v_mode=0: x++; at X_COLS-1, x=0 and y++; at Y_BANKS-1, y=0.
    - v_mode=1: y++; at Y_BANKS-1, y=0 and x++; x wraps to 0.
- Command byte (dc=0): cmd_valid=1, cmd_byte=byte.
  - 0010_0PVH: function set, decoded in either H.
  - H=0:
    - 0000_1D0E: disp_mode={D,E}.
    - 0100_0YYY: y=YYY; values ≥Y_BANKS clamp to Y_BANKS-1.
    - 1XXX_XXXX: x=X; values ≥X_COLS clamp to X_COLS-1.
  - H=1:
    - 1VVV_VVVV: vop.
    - 0001_0BBB: bias.
    - 0000_01TT: tc.
  - All other bytes, including 0x00: cmd_valid only, no state change.
- Data is accepted regardless of pd.
- Function-set and pointer updates take effect for the next byte.

Optional Feature:
- PCD8544_FRAMEBUF_EN:
  - Defined: internal 504x8 RAM written by wr_en; rd_data = mem[rd_addr] registered, 1-cycle latency; RAM is not cleared by reset.
  - Undefined: no RAM; rd_data tied 0; rd_addr ignored.

Decomposition:
- Package pcd8544_pkg:
  - opcode masks/values: FUNC_SET, DISP_CTRL, SET_Y, SET_X, SET_VOP, SET_BIAS, SET_TC.
  - X_MAX=83, Y_MAX=5, FB_DEPTH=504.
  - state enum {IDLE, SHIFT, DISPATCH}.
- Sub-module spi_byte_rx: synchroniser, edge detect, bit counter, sce abort; outputs byte, dc, byte_done.
- Top: decode, pointer, optional RAM.

Test Plan:
- Init 0x21,0x90,0x20,0x0C with dc=0 -> h_ext=1 then 0, vop=0x10, disp_mode=2'b10, four cmd_valid pulses.
- 0xA1,0x42 cmd then data 0xFE,0x81 -> x=33, y=2; writes addr 201=0xFE, 202=0x81; x_ptr=35.
- v_mode=0, x=83, y=5, data 0x55 -> write addr 503, then x=0, y=0. With 0x22 (v_mode=1), y=5, x=83 -> same write, then y=0, x=0.
- sce raised after 5 bits, then full byte 0x3C dc=1 -> only one wr_en, data 0x3C.
- Set-X 0xFF / set-Y 0x47 -> x=83, y=5 (clamped); lcd_rst low mid-byte -> pointer 0, pd=1, no strobe.
- PCD8544_FRAMEBUF_EN: 504 data bytes of 0x00 then 0xAA at addr 0 -> rd_addr 0 gives 0xAA next cycle; rd_addr 1 gives 0x00.

Source files
------------

// File: rtl/pcd8544_pkg.sv
// Shared opcodes, geometry constants, receiver state type and decode helper
// for the PCD8544 SPI receiver.
package pcd8544_pkg;

  localparam int X_MAX    = 83;
  localparam int Y_MAX    = 5;
  localparam int FB_DEPTH = 504;

  localparam logic [7:0] FUNC_SET_MASK  = 8'hF8;
  localparam logic [7:0] FUNC_SET_VAL   = 8'h20;
  localparam logic [7:0] DISP_CTRL_MASK = 8'hFA;
  localparam logic [7:0] DISP_CTRL_VAL  = 8'h08;
  localparam logic [7:0] SET_Y_MASK     = 8'hF8;
  localparam logic [7:0] SET_Y_VAL      = 8'h40;
  localparam logic [7:0] SET_X_MASK     = 8'h80;
  localparam logic [7:0] SET_X_VAL      = 8'h80;
  localparam logic [7:0] SET_VOP_MASK   = 8'h80;
  localparam logic [7:0] SET_VOP_VAL    = 8'h80;
  localparam logic [7:0] SET_BIAS_MASK  = 8'hF8;
  localparam logic [7:0] SET_BIAS_VAL   = 8'h10;
  localparam logic [7:0] SET_TC_MASK    = 8'hFC;
  localparam logic [7:0] SET_TC_VAL     = 8'h04;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    DISPATCH = 2'd2
  } rx_state_e;

  function automatic logic op_match(input logic [7:0] b, input logic [7:0] mask,
                                    input logic [7:0] val);
    return (b & mask) == val;
  endfunction

endpackage

// File: rtl/pcd8544_spi_receiver_byte_rx.sv
// spi_byte_rx: synchronises the lcd_* pins, detects sclk rising edges and
// assembles MSB-first bytes; byte_done pulses for one clock per completed byte.
module spi_byte_rx
  import pcd8544_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lcd_sce,
  input  logic       lcd_sclk,
  input  logic       lcd_mosi,
  input  logic       lcd_dc,
  input  logic       lcd_rst,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       byte_done,
  output logic       disp_rst
);

  logic [SYNC_STAGES-1:0] sce_sync_r, sclk_sync_r, mosi_sync_r, dc_sync_r, rst_sync_r;
  logic                   sclk_prev_r;
  logic [2:0]             bit_cnt_r;
  logic [6:0]             shift_r;
  logic [7:0]             byte_r;
  logic                   dc_r;
  rx_state_e              state_r, state_s;
  logic                   sce_s, sclk_s, mosi_s, dc_s, rise_s, abort_s;

  // Pin synchronisers; chip enable and display reset idle in their inactive state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sce_sync_r  <= {SYNC_STAGES{1'b1}};
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      dc_sync_r   <= {SYNC_STAGES{1'b0}};
      rst_sync_r  <= {SYNC_STAGES{1'b1}};
      sclk_prev_r <= 1'b0;
    end else begin
      sce_sync_r  <= {sce_sync_r[SYNC_STAGES-2:0], lcd_sce};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], lcd_sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], lcd_mosi};
      dc_sync_r   <= {dc_sync_r[SYNC_STAGES-2:0], lcd_dc};
      rst_sync_r  <= {rst_sync_r[SYNC_STAGES-2:0], lcd_rst};
      sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
    end
  end

  assign sce_s    = sce_sync_r[SYNC_STAGES-1];
  assign sclk_s   = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_r[SYNC_STAGES-1];
  assign dc_s     = dc_sync_r[SYNC_STAGES-1];
  assign disp_rst = ~rst_sync_r[SYNC_STAGES-1];
  assign rise_s   = sclk_s & ~sclk_prev_r;
  assign abort_s  = sce_s | disp_rst;

  // Receiver state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a deselect or display reset always returns to IDLE.
  always_comb begin
    state_s = state_r;
    if (abort_s) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:     state_s = (rise_s && bit_cnt_r == 3'd7) ? DISPATCH : SHIFT;
        SHIFT:    state_s = (rise_s && bit_cnt_r == 3'd7) ? DISPATCH : SHIFT;
        DISPATCH: state_s = SHIFT;
        default:  state_s = IDLE;
      endcase
    end
  end

  // Bit counter and shifter; the byte and dc latch on the eighth edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 7'd0;
      byte_r    <= 8'd0;
      dc_r      <= 1'b0;
    end else if (abort_s) begin
      bit_cnt_r <= 3'd0;
    end else if (rise_s) begin
      bit_cnt_r <= bit_cnt_r + 3'd1;
      shift_r   <= {shift_r[5:0], mosi_s};
      if (bit_cnt_r == 3'd7) begin
        byte_r <= {shift_r, mosi_s};
        dc_r   <= dc_s;
      end
    end
  end

  assign rx_byte   = byte_r;
  assign rx_dc     = dc_r;
  assign byte_done = (state_r == DISPATCH);

endmodule

// File: rtl/pcd8544_spi_receiver.sv
// PCD8544 display-side model: command decode, X/Y pointer and write strobes.
// Define PCD8544_FRAMEBUF_EN to add the 504x8 framebuffer behind rd_addr/rd_data.
module pcd8544_spi_receiver
  import pcd8544_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int X_COLS      = X_MAX + 1,
  parameter int Y_BANKS     = Y_MAX + 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lcd_sce,
  input  logic       lcd_sclk,
  input  logic       lcd_mosi,
  input  logic       lcd_dc,
  input  logic       lcd_rst,
  output logic       wr_en,
  output logic [8:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       pd,
  output logic       v_mode,
  output logic       h_ext,
  output logic [1:0] disp_mode,
  output logic [6:0] vop,
  output logic [2:0] bias,
  output logic [1:0] tc,
  output logic [6:0] x_ptr,
  output logic [2:0] y_ptr,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam logic [6:0] X_LAST = 7'(X_COLS - 1);
  localparam logic [2:0] Y_LAST = 3'(Y_BANKS - 1);

  logic [7:0] byte_s;
  logic       dc_s, byte_done_s, disp_rst_s;

  logic       wr_en_r, cmd_valid_r, pd_r, v_mode_r, h_ext_r;
  logic [8:0] wr_addr_r;
  logic [7:0] wr_data_r, cmd_byte_r;
  logic [1:0] disp_mode_r, tc_r;
  logic [6:0] vop_r, x_ptr_r;
  logic [2:0] bias_r, y_ptr_r;

  logic       wr_en_s, cmd_valid_s, pd_s, v_mode_s, h_ext_s;
  logic [8:0] wr_addr_s, lin_addr_s;
  logic [7:0] wr_data_s, cmd_byte_s;
  logic [1:0] disp_mode_s, tc_s;
  logic [6:0] vop_s, x_ptr_s, adv_x_s, set_x_s;
  logic [2:0] bias_s, y_ptr_s, adv_y_s, set_y_s;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
    .clock     (clock),
    .reset     (reset),
    .lcd_sce   (lcd_sce),
    .lcd_sclk  (lcd_sclk),
    .lcd_mosi  (lcd_mosi),
    .lcd_dc    (lcd_dc),
    .lcd_rst   (lcd_rst),
    .rx_byte   (byte_s),
    .rx_dc     (dc_s),
    .byte_done (byte_done_s),
    .disp_rst  (disp_rst_s)
  );

  assign lin_addr_s = 9'(y_ptr_r) * 9'(X_COLS) + 9'(x_ptr_r);
  assign set_x_s    = (byte_s[6:0] > X_LAST) ? X_LAST : byte_s[6:0];
  assign set_y_s    = (byte_s[2:0] > Y_LAST) ? Y_LAST : byte_s[2:0];

  // Post-write pointer: horizontal mode walks columns first, vertical walks banks.
  always_comb begin
    adv_x_s = x_ptr_r;
    adv_y_s = y_ptr_r;
    if (!v_mode_r) begin
      if (x_ptr_r == X_LAST) begin
        adv_x_s = 7'd0;
        adv_y_s = (y_ptr_r == Y_LAST) ? 3'd0 : y_ptr_r + 3'd1;
      end else begin
        adv_x_s = x_ptr_r + 7'd1;
      end
    end else begin
      if (y_ptr_r == Y_LAST) begin
        adv_y_s = 3'd0;
        adv_x_s = (x_ptr_r == X_LAST) ? 7'd0 : x_ptr_r + 7'd1;
      end else begin
        adv_y_s = y_ptr_r + 3'd1;
      end
    end
  end

  // Byte dispatch: data writes, command decode, and display reset.
  always_comb begin
    wr_en_s     = 1'b0;
    cmd_valid_s = 1'b0;
    wr_addr_s   = wr_addr_r;
    wr_data_s   = wr_data_r;
    cmd_byte_s  = cmd_byte_r;
    pd_s        = pd_r;
    v_mode_s    = v_mode_r;
    h_ext_s     = h_ext_r;
    disp_mode_s = disp_mode_r;
    vop_s       = vop_r;
    bias_s      = bias_r;
    tc_s        = tc_r;
    x_ptr_s     = x_ptr_r;
    y_ptr_s     = y_ptr_r;
    if (disp_rst_s) begin
      wr_addr_s   = 9'd0;
      wr_data_s   = 8'd0;
      cmd_byte_s  = 8'd0;
      pd_s        = 1'b1;
      v_mode_s    = 1'b0;
      h_ext_s     = 1'b0;
      disp_mode_s = 2'd0;
      vop_s       = 7'd0;
      bias_s      = 3'd0;
      tc_s        = 2'd0;
      x_ptr_s     = 7'd0;
      y_ptr_s     = 3'd0;
    end else if (byte_done_s && dc_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = lin_addr_s;
      wr_data_s = byte_s;
      x_ptr_s   = adv_x_s;
      y_ptr_s   = adv_y_s;
    end else if (byte_done_s) begin
      cmd_valid_s = 1'b1;
      cmd_byte_s  = byte_s;
      if (op_match(byte_s, FUNC_SET_MASK, FUNC_SET_VAL)) begin
        {pd_s, v_mode_s, h_ext_s} = byte_s[2:0];
      end else if (!h_ext_r) begin
        if (op_match(byte_s, DISP_CTRL_MASK, DISP_CTRL_VAL)) begin
          disp_mode_s = {byte_s[2], byte_s[0]};
        end else if (op_match(byte_s, SET_Y_MASK, SET_Y_VAL)) begin
          y_ptr_s = set_y_s;
        end else if (op_match(byte_s, SET_X_MASK, SET_X_VAL)) begin
          x_ptr_s = set_x_s;
        end else begin
          disp_mode_s = disp_mode_r;
        end
      end else begin
        if (op_match(byte_s, SET_VOP_MASK, SET_VOP_VAL)) begin
          vop_s = byte_s[6:0];
        end else if (op_match(byte_s, SET_BIAS_MASK, SET_BIAS_VAL)) begin
          bias_s = byte_s[2:0];
        end else if (op_match(byte_s, SET_TC_MASK, SET_TC_VAL)) begin
          tc_s = byte_s[1:0];
        end else begin
          vop_s = vop_r;
        end
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Output and control registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en_r     <= 1'b0;
      cmd_valid_r <= 1'b0;
      wr_addr_r   <= 9'd0;
      wr_data_r   <= 8'd0;
      cmd_byte_r  <= 8'd0;
      pd_r        <= 1'b1;
      v_mode_r    <= 1'b0;
      h_ext_r     <= 1'b0;
      disp_mode_r <= 2'd0;
      vop_r       <= 7'd0;
      bias_r      <= 3'd0;
      tc_r        <= 2'd0;
      x_ptr_r     <= 7'd0;
      y_ptr_r     <= 3'd0;
    end else begin
      wr_en_r     <= wr_en_s;
      cmd_valid_r <= cmd_valid_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      cmd_byte_r  <= cmd_byte_s;
      pd_r        <= pd_s;
      v_mode_r    <= v_mode_s;
      h_ext_r     <= h_ext_s;
      disp_mode_r <= disp_mode_s;
      vop_r       <= vop_s;
      bias_r      <= bias_s;
      tc_r        <= tc_s;
      x_ptr_r     <= x_ptr_s;
      y_ptr_r     <= y_ptr_s;
    end
  end

  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_byte  = cmd_byte_r;
  assign pd        = pd_r;
  assign v_mode    = v_mode_r;
  assign h_ext     = h_ext_r;
  assign disp_mode = disp_mode_r;
  assign vop       = vop_r;
  assign bias      = bias_r;
  assign tc        = tc_r;
  assign x_ptr     = x_ptr_r;
  assign y_ptr     = y_ptr_r;

`ifdef PCD8544_FRAMEBUF_EN
  logic [7:0] fb_mem_r [FB_DEPTH];
  logic [7:0] rd_data_r;

  // Framebuffer write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_en_r) begin
      fb_mem_r[wr_addr_r] <= wr_data_r;
    end
  end

  // Registered read port, out-of-range addresses read as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_r <= 8'd0;
    end else if (rd_addr < 9'(FB_DEPTH)) begin
      rd_data_r <= fb_mem_r[rd_addr];
    end else begin
      rd_data_r <= 8'd0;
    end
  end

  assign rd_data = rd_data_r;
`else
  logic rd_addr_unused_s;
  assign rd_addr_unused_s = ^rd_addr;
  assign rd_data          = 8'd0;
`endif

endmodule

// File: tb/tb_pcd8544_spi_receiver.sv
// Randomised self-checking bench for pcd8544_spi_receiver against a behavioural
// display model; the framebuffer section depends on PCD8544_FRAMEBUF_EN.
module tb_pcd8544_spi_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_sce = 1'b1, lcd_sclk = 1'b0, lcd_mosi = 1'b0, lcd_dc = 1'b0, lcd_rst = 1'b1;
  logic [8:0] rd_addr = 9'd0;
  logic       wr_en, cmd_valid, pd, v_mode, h_ext;
  logic [8:0] wr_addr;
  logic [7:0] wr_data, cmd_byte, rd_data;
  logic [1:0] disp_mode, tc;
  logic [6:0] vop, x_ptr;
  logic [2:0] bias, y_ptr;

  pcd8544_spi_receiver dut (
    .clock(clock), .reset(reset), .lcd_sce(lcd_sce), .lcd_sclk(lcd_sclk),
    .lcd_mosi(lcd_mosi), .lcd_dc(lcd_dc), .lcd_rst(lcd_rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pd(pd), .v_mode(v_mode),
    .h_ext(h_ext), .disp_mode(disp_mode), .vop(vop), .bias(bias), .tc(tc),
    .x_ptr(x_ptr), .y_ptr(y_ptr), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit is_data;
    int addr, data, pd, v, h, disp, vop, bias, tc, x, y;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, passes = 0;
  int  wr_count = 0, cmd_count = 0, last_wr_addr = -1, last_wr_data = -1;
  int  m_pd = 1, m_v = 0, m_h = 0, m_disp = 0, m_vop = 0, m_bias = 0, m_tc = 0, m_x = 0, m_y = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    m_pd = 1; m_v = 0; m_h = 0; m_disp = 0; m_vop = 0; m_bias = 0; m_tc = 0; m_x = 0; m_y = 0;
  endfunction

  // Display behaviour: linear framebuffer index arithmetic for the pointer.
  function automatic void model_byte(input logic [7:0] b, input logic dc);
    ev_t e;
    int  idx;
    e.is_data = dc; e.data = int'(b); e.addr = 0;
    if (dc) begin
      e.addr = m_y * 84 + m_x;
      if (m_v == 0) begin
        idx = (m_y * 84 + m_x + 1) % 504; m_y = idx / 84; m_x = idx % 84;
      end else begin
        idx = (m_x * 6 + m_y + 1) % 504; m_x = idx / 6; m_y = idx % 6;
      end
    end else if (b[7:3] == 5'b00100) begin
      m_pd = int'(b[2]); m_v = int'(b[1]); m_h = int'(b[0]);
    end else if (m_h == 0) begin
      if (b[7:3] == 5'b00001 && b[1] == 1'b0) m_disp = int'({b[2], b[0]});
      else if (b[7:3] == 5'b01000) m_y = (int'(b[2:0]) > 5) ? 5 : int'(b[2:0]);
      else if (b[7]) m_x = (int'(b[6:0]) > 83) ? 83 : int'(b[6:0]);
    end else begin
      if (b[7]) m_vop = int'(b[6:0]);
      else if (b[7:3] == 5'b00010) m_bias = int'(b[2:0]);
      else if (b[7:2] == 6'b000001) m_tc = int'(b[1:0]);
    end
    e.pd = m_pd; e.v = m_v; e.h = m_h; e.disp = m_disp; e.vop = m_vop;
    e.bias = m_bias; e.tc = m_tc; e.x = m_x; e.y = m_y;
    exp_q.push_back(e);
  endfunction

  // Compare process: every strobe must match the next modelled byte.
  always @(negedge clock) begin
    ev_t e;
    if (!reset && (wr_en || cmd_valid)) begin
      if (wr_en) begin wr_count++; last_wr_addr = int'(wr_addr); last_wr_data = int'(wr_data); end
      if (cmd_valid) cmd_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe wr_en", int'(wr_en), int'(e.is_data));
        chk("strobe cmd_valid", int'(cmd_valid), int'(!e.is_data));
        if (e.is_data) begin
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("wr_data", int'(wr_data), e.data);
        end else begin
          chk("cmd_byte", int'(cmd_byte), e.data);
        end
        chk("pd", int'(pd), e.pd);       chk("v_mode", int'(v_mode), e.v);
        chk("h_ext", int'(h_ext), e.h);  chk("disp_mode", int'(disp_mode), e.disp);
        chk("vop", int'(vop), e.vop);    chk("bias", int'(bias), e.bias);
        chk("tc", int'(tc), e.tc);       chk("x_ptr", int'(x_ptr), e.x);
        chk("y_ptr", int'(y_ptr), e.y);
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      lcd_mosi = b[7-i];
      lcd_dc   = dc;
      wait_clks(4);
      if (i == 7) model_byte(b, dc);
      lcd_sclk = 1'b1;
      wait_clks(4);
      lcd_sclk = 1'b0;
    end
  endtask

  task automatic sce_low();
    lcd_sce = 1'b0;
    wait_clks(4);
  endtask

  task automatic sce_high();
    wait_clks(8);
    lcd_sce = 1'b1;
    wait_clks(6);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic dc);
    sce_low();
    send_bits(b, dc, 8);
    sce_high();
  endtask

  task automatic pulse_lcd_rst();
    lcd_rst = 1'b0;
    wait_clks(6);
    model_reset();
    lcd_rst = 1'b1;
    wait_clks(4);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " pd"}, int'(pd), m_pd);             chk({tag, " v_mode"}, int'(v_mode), m_v);
    chk({tag, " h_ext"}, int'(h_ext), m_h);        chk({tag, " disp_mode"}, int'(disp_mode), m_disp);
    chk({tag, " vop"}, int'(vop), m_vop);          chk({tag, " bias"}, int'(bias), m_bias);
    chk({tag, " tc"}, int'(tc), m_tc);             chk({tag, " x_ptr"}, int'(x_ptr), m_x);
    chk({tag, " y_ptr"}, int'(y_ptr), m_y);
  endtask

  initial begin
    int n, c, nb;
    logic [7:0] rb;
    logic       rdc;
    wait_clks(3);
    chk("reset wr_en", int'(wr_en), 0);      chk("reset cmd_valid", int'(cmd_valid), 0);
    chk("reset wr_addr", int'(wr_addr), 0);  chk("reset wr_data", int'(wr_data), 0);
    chk("reset cmd_byte", int'(cmd_byte), 0); chk("reset rd_data", int'(rd_data), 0);
    check_model("reset");
    chk("reset pd literal", int'(pd), 1);
    reset = 1'b0;
    wait_clks(4);

    // Init sequence.
    send_frame(8'h21, 1'b0);
    chk("init h_ext after 0x21", int'(h_ext), 1);
    send_frame(8'h90, 1'b0);
    send_frame(8'h20, 1'b0);
    send_frame(8'h0C, 1'b0);
    chk("init h_ext", int'(h_ext), 0);
    chk("init vop", int'(vop), 16);
    chk("init disp_mode", int'(disp_mode), 2);
    chk("init cmd pulses", cmd_count, 4);

    // Pointer commands then two data bytes.
    sce_low();
    send_bits(8'hA1, 1'b0, 8);
    send_bits(8'h42, 1'b0, 8);
    sce_high();
    chk("set x_ptr", int'(x_ptr), 33);
    chk("set y_ptr", int'(y_ptr), 2);
    send_frame(8'hFE, 1'b1);
    chk("write1 addr", last_wr_addr, 201);
    chk("write1 data", last_wr_data, 254);
    send_frame(8'h81, 1'b1);
    chk("write2 addr", last_wr_addr, 202);
    chk("write2 data", last_wr_data, 129);
    chk("after writes x_ptr", int'(x_ptr), 35);

    // Last-cell wrap, horizontal then vertical.
    send_frame(8'hD3, 1'b0);
    send_frame(8'h45, 1'b0);
    send_frame(8'h55, 1'b1);
    chk("hwrap addr", last_wr_addr, 503);
    chk("hwrap x_ptr", int'(x_ptr), 0);
    chk("hwrap y_ptr", int'(y_ptr), 0);
    send_frame(8'h22, 1'b0);
    send_frame(8'hD3, 1'b0);
    send_frame(8'h45, 1'b0);
    send_frame(8'h55, 1'b1);
    chk("vwrap v_mode", int'(v_mode), 1);
    chk("vwrap addr", last_wr_addr, 503);
    chk("vwrap x_ptr", int'(x_ptr), 0);
    chk("vwrap y_ptr", int'(y_ptr), 0);

    // Partial byte aborted by deselect, then a full byte.
    send_frame(8'h20, 1'b0);
    n = wr_count;
    sce_low();
    send_bits(8'hE7, 1'b1, 5);
    sce_high();
    send_frame(8'h3C, 1'b1);
    chk("abort write count", wr_count - n, 1);
    chk("abort data", last_wr_data, 60);
    chk("abort addr", last_wr_addr, 0);

    // Clamping and display reset mid-byte.
    send_frame(8'hFF, 1'b0);
    send_frame(8'h47, 1'b0);
    chk("clamp x_ptr", int'(x_ptr), 83);
    chk("clamp y_ptr", int'(y_ptr), 5);
    n = wr_count;
    c = cmd_count;
    sce_low();
    send_bits(8'h5A, 1'b1, 4);
    pulse_lcd_rst();
    sce_high();
    chk("lcd_rst x_ptr", int'(x_ptr), 0);
    chk("lcd_rst y_ptr", int'(y_ptr), 0);
    chk("lcd_rst pd", int'(pd), 1);
    chk("lcd_rst vop", int'(vop), 0);
    chk("lcd_rst no strobe", (wr_count - n) + (cmd_count - c), 0);
    check_model("after lcd_rst");

    // Random frames, occasionally ending in an aborted partial byte.
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 4);
      sce_low();
      for (int j = 0; j < nb; j++) begin
        rb  = 8'($urandom_range(0, 255));
        rdc = 1'($urandom_range(0, 1));
        send_bits(rb, rdc, 8);
      end
      if ($urandom_range(0, 4) == 0) begin
        rb = 8'($urandom_range(0, 255));
        send_bits(rb, 1'b1, $urandom_range(1, 7));
      end
      sce_high();
    end
    check_model("random");

`ifdef PCD8544_FRAMEBUF_EN
    pulse_lcd_rst();
    sce_low();
    for (int k = 0; k < 504; k++) send_bits(8'h00, 1'b1, 8);
    send_bits(8'hAA, 1'b1, 8);
    sce_high();
    rd_addr = 9'd0;
    wait_clks(1);
    chk("fb rd 0", int'(rd_data), 170);
    rd_addr = 9'd1;
    wait_clks(1);
    chk("fb rd 1", int'(rd_data), 0);
    rd_addr = 9'd503;
    wait_clks(1);
    chk("fb rd 503", int'(rd_data), 0);
`else
    rd_addr = 9'd0;
    wait_clks(1);
    chk("no fb rd 0", int'(rd_data), 0);
    rd_addr = 9'($urandom_range(1, 503));
    wait_clks(1);
    chk("no fb rd rand", int'(rd_data), 0);
`endif

    wait_clks(10);
    chk("pending strobes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
